// File: rtl/encoder_axi_master.sv
// AXI4-Lite initiator: converts single-beat commands into AXI4-Lite reads/writes, one at a time.
// Optional per-channel wait timeout enabled by defining AXIL_TIMEOUT_EN.
module encoder_axi_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              cmd_valid,
    output logic              CMD_READY,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              RSP_VALID,
    input  logic              rsp_ready,
    output logic [31:0]       RSP_RDATA,
    output logic [1:0]        RSP_RESP,
    output logic              RSP_TIMEOUT,
    output logic [ADDR_W-1:0] AW_ADDR,
    output logic              AW_VALID,
    input  logic              aw_ready,
    output logic [31:0]       W_DATA,
    output logic [3:0]        W_STRB,
    output logic              W_VALID,
    input  logic              w_ready,
    input  logic [1:0]        b_resp,
    input  logic              b_valid,
    output logic              B_READY,
    output logic [ADDR_W-1:0] AR_ADDR,
    output logic              AR_VALID,
    input  logic              ar_ready,
    input  logic [31:0]       r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_valid,
    output logic              R_READY
);

    localparam int unsigned CNT_W = 16;

    // The wait counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("encoder_axi_master: TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WRESP   = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic                aw_valid_q, aw_valid_d;
    logic [31:0]         w_data_q, w_data_d;
    logic [3:0]          w_strb_q, w_strb_d;
    logic                w_valid_q, w_valid_d;
    logic                b_ready_q, b_ready_d;
    logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
    logic                ar_valid_q, ar_valid_d;
    logic                r_ready_q, r_ready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
`ifdef AXIL_TIMEOUT_EN
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                waiting_c;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        aw_addr_d     = aw_addr_q;
        aw_valid_d    = aw_valid_q;
        w_data_d      = w_data_q;
        w_strb_d      = w_strb_q;
        w_valid_d     = w_valid_q;
        b_ready_d     = b_ready_q;
        ar_addr_d     = ar_addr_q;
        ar_valid_d    = ar_valid_q;
        r_ready_d     = r_ready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        aw_addr_d  = cmd_addr;
                        w_data_d   = cmd_wdata;
                        w_strb_d   = cmd_wstrb;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                        state_d    = WR;
                    end else begin
                        ar_addr_d  = cmd_addr;
                        ar_valid_d = 1'b1;
                        state_d    = RD_ADDR;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; B is opened once both are done
                if (aw_valid_q && aw_ready) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_valid_q && w_ready) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_ready_d = 1'b1;
                    state_d   = WRESP;
                end
            end
            WRESP: begin
                if (b_valid) begin
                    rsp_resp_d  = b_resp;
                    rsp_rdata_d = 32'd0;
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_ADDR: begin
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_valid) begin
                    rsp_rdata_d = r_data;
                    rsp_resp_d  = r_resp;
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    cmd_ready_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase

`ifdef AXIL_TIMEOUT_EN
        // Abort a hung channel: withdraw everything and report DECERR with the timeout flag
        waiting_c = (state_q == WR) || (state_q == WRESP) ||
                    (state_q == RD_ADDR) || (state_q == RD_DATA);
        cnt_d = '0;
        if (waiting_c && (state_d == state_q)) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                aw_valid_d    = 1'b0;
                w_valid_d     = 1'b0;
                b_ready_d     = 1'b0;
                ar_valid_d    = 1'b0;
                r_ready_d     = 1'b0;
                aw_done_d     = 1'b0;
                w_done_d      = 1'b0;
                rsp_resp_d    = 2'b11;
                rsp_rdata_d   = 32'd0;
                rsp_timeout_d = 1'b1;
                rsp_valid_d   = 1'b1;
                state_d       = RSP;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            aw_addr_q     <= '0;
            aw_valid_q    <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            w_valid_q     <= 1'b0;
            b_ready_q     <= 1'b0;
            ar_addr_q     <= '0;
            ar_valid_q    <= 1'b0;
            r_ready_q     <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            aw_addr_q     <= aw_addr_d;
            aw_valid_q    <= aw_valid_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            w_valid_q     <= w_valid_d;
            b_ready_q     <= b_ready_d;
            ar_addr_q     <= ar_addr_d;
            ar_valid_q    <= ar_valid_d;
            r_ready_q     <= r_ready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
`ifdef AXIL_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign CMD_READY   = cmd_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_RESP    = rsp_resp_q;
    assign RSP_TIMEOUT = rsp_timeout_q;
    assign AW_ADDR     = aw_addr_q;
    assign AW_VALID    = aw_valid_q;
    assign W_DATA      = w_data_q;
    assign W_STRB      = w_strb_q;
    assign W_VALID     = w_valid_q;
    assign B_READY     = b_ready_q;
    assign AR_ADDR     = ar_addr_q;
    assign AR_VALID    = ar_valid_q;
    assign R_READY     = r_ready_q;

endmodule

// File: tb/tb_encoder_axi_master.sv
// Directed bench for encoder_axi_master; the bench plays the AXI4-Lite slave cycle by cycle.
module tb_encoder_axi_master;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_ready;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] r_data;

    logic        cmd_ready_o, rsp_valid_o, rsp_timeout_o;
    logic [31:0] rsp_rdata_o, aw_addr_o, w_data_o, ar_addr_o;
    logic [1:0]  rsp_resp_o;
    logic [3:0]  w_strb_o;
    logic        aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    encoder_axi_master #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .cmd_valid(cmd_valid), .CMD_READY(cmd_ready_o), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .RSP_VALID(rsp_valid_o), .rsp_ready(rsp_ready), .RSP_RDATA(rsp_rdata_o),
        .RSP_RESP(rsp_resp_o), .RSP_TIMEOUT(rsp_timeout_o),
        .AW_ADDR(aw_addr_o), .AW_VALID(aw_valid_o), .aw_ready(aw_ready),
        .W_DATA(w_data_o), .W_STRB(w_strb_o), .W_VALID(w_valid_o), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .B_READY(b_ready_o),
        .AR_ADDR(ar_addr_o), .AR_VALID(ar_valid_o), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .R_READY(r_ready_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic rsp_handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_drop"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_cmd_ready_back"}, 32'(cmd_ready_o), 32'd1);
    endtask

    initial begin
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_resp = '0; r_data = '0;
        tick(); tick();

        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_valids", {27'd0, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o}, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_w_strb", 32'(w_strb_o), 32'd0);
        aresetn = 1'b1;
        tick();

        // Write 0x1 to 0x00; AW and W accepted together two cycles after VALID
        send_cmd(1'b1, 32'h0, 32'h1, 4'hF);
        check("w1_cmd_ready_low", 32'(cmd_ready_o), 32'd0);
        check("w1_aw_valid", 32'(aw_valid_o), 32'd1);
        check("w1_w_valid", 32'(w_valid_o), 32'd1);
        check("w1_aw_addr", aw_addr_o, 32'h0);
        check("w1_w_data", w_data_o, 32'h1);
        check("w1_w_strb", 32'(w_strb_o), 32'hF);
        tick();
        check("w1_hold_valids", {30'd0, aw_valid_o, w_valid_o}, 32'd3);
        check("w1_hold_data", w_data_o, 32'h1);
        aw_ready = 1'b1; w_ready = 1'b1;
        tick();
        aw_ready = 1'b0; w_ready = 1'b0;
        check("w1_valids_drop", {30'd0, aw_valid_o, w_valid_o}, 32'd0);
        check("w1_b_ready", 32'(b_ready_o), 32'd1);
        b_valid = 1'b1; b_resp = 2'b00;
        tick();
        b_valid = 1'b0;
        check("w1_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("w1_rsp_resp", 32'(rsp_resp_o), 32'd0);
        check("w1_rsp_rdata", rsp_rdata_o, 32'd0);
        check("w1_b_ready_drop", 32'(b_ready_o), 32'd0);
        rsp_handshake("w1");

        // Write with W accepted three cycles before AW
        send_cmd(1'b1, 32'h8, 32'hA5A5_0F0F, 4'h3);
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        check("w2_w_drop", 32'(w_valid_o), 32'd0);
        check("w2_aw_hold", 32'(aw_valid_o), 32'd1);
        tick(); tick();
        check("w2_aw_still", 32'(aw_valid_o), 32'd1);
        check("w2_aw_addr", aw_addr_o, 32'h8);
        check("w2_no_b_ready", 32'(b_ready_o), 32'd0);
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0;
        check("w2_aw_drop", 32'(aw_valid_o), 32'd0);
        check("w2_b_ready", 32'(b_ready_o), 32'd1);
        b_valid = 1'b1; b_resp = 2'b01;
        tick();
        b_valid = 1'b0;
        check("w2_rsp", {29'd0, rsp_valid_o, rsp_resp_o}, 32'h5);
        rsp_handshake("w2");

        // Read 0x04 with data four cycles after the address phase
        send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
        check("r1_ar_valid", 32'(ar_valid_o), 32'd1);
        check("r1_ar_addr", ar_addr_o, 32'h4);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        check("r1_ar_drop", 32'(ar_valid_o), 32'd0);
        check("r1_r_ready", 32'(r_ready_o), 32'd1);
        tick(); tick(); tick();
        check("r1_r_ready_hold", 32'(r_ready_o), 32'd1);
        r_valid = 1'b1; r_data = 32'h0000_0123; r_resp = 2'b00;
        tick();
        r_valid = 1'b0;
        check("r1_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("r1_rsp_rdata", rsp_rdata_o, 32'h123);
        check("r1_rsp_resp", 32'(rsp_resp_o), 32'd0);
        check("r1_r_ready_drop", 32'(r_ready_o), 32'd0);
        rsp_handshake("r1");

        // Read 0x10 with SLVERR; response stalled five cycles while a write waits
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        r_valid = 1'b1; r_data = 32'hDEAD_BEEF; r_resp = 2'b10;
        tick();
        r_valid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20;
        cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("r2_stall_valid", 32'(rsp_valid_o), 32'd1);
            check("r2_stall_resp", 32'(rsp_resp_o), 32'h2);
            check("r2_stall_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
            check("r2_stall_cmd_ready", 32'(cmd_ready_o), 32'd0);
            check("r2_no_latch", 32'(aw_valid_o), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("r2_idle_bubble", {29'd0, rsp_valid_o, cmd_ready_o, aw_valid_o}, 32'h2);
        tick();
        cmd_valid = 1'b0;
        check("r2_next_cmd_aw", 32'(aw_valid_o), 32'd1);
        check("r2_next_cmd_addr", aw_addr_o, 32'h20);

        // Reset asserted in WRESP, then a normal read
        aw_ready = 1'b1; w_ready = 1'b1;
        tick();
        aw_ready = 1'b0; w_ready = 1'b0;
        check("rst2_in_wresp", 32'(b_ready_o), 32'd1);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        check("rst2_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst2_valids", {26'd0, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, rsp_valid_o}, 32'd0);
        check("rst2_aw_addr", aw_addr_o, 32'd0);
        check("rst2_w_data", w_data_o, 32'd0);
        check("rst2_rsp_rdata", rsp_rdata_o, 32'd0);
        check("rst2_rsp_resp", 32'(rsp_resp_o), 32'd0);
        tick();
        send_cmd(1'b0, 32'hC, 32'h0, 4'h0);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        r_valid = 1'b1; r_data = 32'h0000_00C0; r_resp = 2'b00;
        tick();
        r_valid = 1'b0;
        check("r3_rsp", {29'd0, rsp_valid_o, rsp_resp_o}, 32'h4);
        check("r3_rdata", rsp_rdata_o, 32'hC0);
        rsp_handshake("r3");

        // Read to 0x40 whose address is never accepted
        send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
`ifdef AXIL_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            check("to_ar_hold", 32'(ar_valid_o), 32'd1);
            tick();
        end
        check("to_ar_drop", 32'(ar_valid_o), 32'd0);
        check("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("to_rsp_resp", 32'(rsp_resp_o), 32'h3);
        check("to_rsp_timeout", 32'(rsp_timeout_o), 32'd1);
        check("to_rsp_rdata", rsp_rdata_o, 32'd0);
        rsp_handshake("to");
        check("to_timeout_clear", 32'(rsp_timeout_o), 32'd0);
`else
        for (int i = 0; i < 40; i++) begin
            check("nto_ar_hold", {30'd0, ar_valid_o, rsp_valid_o}, 32'h2);
            tick();
        end
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        r_valid = 1'b1; r_data = 32'h0000_0040; r_resp = 2'b11;
        tick();
        r_valid = 1'b0;
        check("nto_rsp", {28'd0, rsp_timeout_o, rsp_valid_o, rsp_resp_o}, 32'h7);
        check("nto_rdata", rsp_rdata_o, 32'h40);
        rsp_handshake("nto");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/encoder_axi_master.md
Name: encoder_axi_master

Overview:
- AXI4-Lite initiator (master) that turns single-beat commands from a simple valid/ready command port into AXI4-Lite read or write transactions.
- Returns each result on a valid/ready response port.
- Used to drive the encoder peripheral's AXI4-Lite slave from local control logic, a polling engine or a bench.
- One outstanding transaction at a time; no bursts, no pipelining.

Parameters:
- ADDR_W, 32, width of cmd_addr and all AXI address outputs
- TIMEOUT_CYCLES, 1024, wait limit per channel; used only when AXIL_TIMEOUT_EN is defined

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- CMD_READY  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- RSP_VALID  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- RSP_RDATA  out  32  read data; 0 for writes
- RSP_RESP  out  2  BRESP or RRESP as received
- RSP_TIMEOUT  out  1  transaction aborted by the timeout
- AW_ADDR  out  ADDR_W
- AW_VALID  out  1
- aw_ready  in  1
- W_DATA  out  32
- W_STRB  out  4
- W_VALID  out  1
- w_ready  in  1
- b_resp  in  2
- b_valid  in  1
- B_READY  out  1
- AR_ADDR  out  ADDR_W
- AR_VALID  out  1
- ar_ready  in  1
- r_data  in  32
- r_resp  in  2
- r_valid  in  1
- R_READY  out  1

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous, active-low (s_axi_aresetn sampled on the s_axi_aclk rising edge).
  - Reset values: all VALID/READY outputs 0, except CMD_READY = 1 in IDLE. All address, data, RSP_* outputs 0. W_STRB = 0. State = IDLE.
- States: IDLE, WR (AW/W phase), WRESP, RD_ADDR, RD_DATA, RSP. All outputs are registered.
- IDLE:
  - CMD_READY = 1.
  - On cmd_valid, the command is latched. Next cycle: CMD_READY = 0, and the state is WR (AW_VALID = 1 and W_VALID = 1) if cmd_write, else RD_ADDR (AR_VALID = 1).
  - First AXI valid appears 1 cycle after the command handshake.
- WR:
  - AW and W complete independently, in either order or in the same cycle.
  - Each VALID holds, with address and data stable, until its own ready is seen high at a clock edge. It then drops on the next cycle.
  - Two internal done flags track AW and W. When both are set, go to WRESP with B_READY = 1.
- WRESP:
  - B_READY held at 1.
  - On b_valid: capture b_resp into RSP_RESP, set RSP_RDATA = 0, drop B_READY, go to RSP.
- RD_ADDR:
  - AR_VALID held until ar_ready.
  - Then AR_VALID = 0 and R_READY = 1, go to RD_DATA.
- RD_DATA:
  - On r_valid: capture r_data and r_resp, drop R_READY, go to RSP.
- RSP:
  - RSP_VALID = 1; the outputs are held stable until rsp_ready.
  - On the rsp_ready handshake, the next cycle has RSP_VALID = 0, CMD_READY = 1, state IDLE.
  - A new command is accepted no earlier than that IDLE cycle, so there is one idle bubble between transactions.
- Responses:
  - SLVERR (2'b10) and DECERR (2'b11) are passed through unchanged. The block never retries.
- Protocol rules:
  - VALID never depends combinationally on READY.
  - No VALID is ever withdrawn before its handshake, except on timeout.
- Reset mid-transaction: every output returns to its reset value on the next edge. Outstanding AXI beats are dropped.
- Commands presented while CMD_READY = 0 are ignored and not latched; the source holds them.

Optional Feature:
- Macro: AXIL_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on each state entry and increments each cycle in WR, WRESP, RD_ADDR and RD_DATA.
  - When it reaches TIMEOUT_CYCLES-1 with no handshake: drop all AXI VALID/READY outputs, set RSP_RESP = 2'b11 and RSP_TIMEOUT = 1, set RSP_RDATA = 0, go to RSP.
  - This is a deliberate protocol abort for a bus deemed hung.
  - RSP_TIMEOUT clears when RSP is left.
- Undefined: no counter is built, RSP_TIMEOUT is tied 0, and the block waits indefinitely.

Test Plan:
- Write cmd addr 0x00, data 0x1, strb 0xF. Slave raises aw_ready and w_ready together 2 cycles after VALID, then b_valid with b_resp 00 → AW_ADDR = 0x00, W_DATA = 0x1 held stable until handshake; RSP_VALID with RSP_RESP = 00, RSP_RDATA = 0.
- Write with w_ready 3 cycles before aw_ready → W_VALID drops after its handshake, AW_VALID stays high until aw_ready, B_READY rises only after both → single response.
- Read addr 0x04; slave returns r_data 0x0000_0123, r_resp 00 after 4 cycles → RSP_RDATA = 0x123, RSP_RESP = 00.
- Read addr 0x10; slave returns r_resp 10; rsp_ready held low for 5 cycles → RSP_RESP = 10, RSP_VALID and data stable all 5 cycles, CMD_READY = 0 until 1 cycle after rsp_ready.
- s_axi_aresetn low in WRESP with B_READY = 1 → next edge all outputs at reset values, CMD_READY = 1; a following read completes normally.
- AXIL_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, slave never asserts ar_ready → AR_VALID drops after 16 cycles, RSP_RESP = 11, RSP_TIMEOUT = 1. With the macro undefined, AR_VALID stays high indefinitely.
